// File: rtl/pipe_hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The master drives ID-stage information; the slave returns pipeline controls.
interface pipe_hazard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_is_branch;
  logic              id_wb_en;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [ADDR_W-1:0] id_dest;
  logic              br_taken;
  logic              dmem_ack;

  logic              freeze_if_id;
  logic              bubble_ex;
  logic              flush_id;
  logic              pipe_hold;
  logic              dmem_req;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_wb_en, id_mem_read, id_mem_write, id_dest, br_taken, dmem_ack,
    input  freeze_if_id, bubble_ex, flush_id, pipe_hold, dmem_req,
           fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_wb_en, id_mem_read, id_mem_write, id_dest, br_taken, dmem_ack,
    output freeze_if_id, bubble_ex, flush_id, pipe_hold, dmem_req,
           fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: tracks EX/MEM/WB shadow slots to
// generate interlock stalls, operand forwarding and data-memory wait holds.
module pipe_hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  pipe_hazard_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic [ADDR_W-1:0] dest;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
  } slot_t;

  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

  slot_t            ex_q, mem_q, wb_q, ex_d;
  mem_state_t       state;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hit_ex, hit_mem;
  logic             stall, dmem_req, pipe_hold, freeze, bubble;

  function automatic logic src_match(input logic              used,
                                     input logic [ADDR_W-1:0] src,
                                     input slot_t             s);
    return used && (src != '0) && s.valid && s.wb_en && (s.dest == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                         input logic              src_valid,
                                         input slot_t             m,
                                         input slot_t             w);
    if (!FWD_EN || !src_valid)                   return 2'd0;
    if (src_match(1'b1, src, m) && !m.mem_read)  return 2'd1;
    if (src_match(1'b1, src, w))                 return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    hit_ex  = src_match(bus.id_use_rs, bus.id_rs, ex_q)  |
              src_match(bus.id_use_rt, bus.id_rt, ex_q);
    hit_mem = src_match(bus.id_use_rs, bus.id_rs, mem_q) |
              src_match(bus.id_use_rt, bus.id_rt, mem_q);
    if (FWD_EN) begin
      // Load-use always stalls; branches need operands in ID, so an ALU result
      // still in EX or a load still in MEM is too late for them.
      stall = bus.id_valid &
              ((hit_ex & ex_q.mem_read) |
               (bus.id_is_branch & (hit_ex | (hit_mem & mem_q.mem_read))));
    end else begin
      stall = bus.id_valid & (hit_ex | hit_mem);
    end
  end

  assign dmem_req  = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
  assign pipe_hold = dmem_req & ~bus.dmem_ack;
  assign freeze    = stall | pipe_hold;
  assign bubble    = stall & ~pipe_hold;

  // NOTE: every field gets a default first so no path through this block can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    ex_d = '0;
    if (bus.id_valid && !bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.wb_en     = bus.id_wb_en;
      ex_d.dest      = bus.id_dest;
      ex_d.mem_read  = bus.id_mem_read;
      ex_d.mem_write = bus.id_mem_write;
      // Unused sources are recorded as r0 so they can never select a bypass.
      ex_d.rs        = bus.id_use_rs ? bus.id_rs : '0;
      ex_d.rt        = bus.id_use_rt ? bus.id_rt : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the EX->MEM->WB
  // shift reads the pre-edge value of every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state       <= S_IDLE;
      stall_cnt_q <= '0;
    end else begin
      if (!pipe_hold) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      case (state)
        S_IDLE:  if (dmem_req && !bus.dmem_ack) state <= S_WAIT;
        S_WAIT:  if (bus.dmem_ack)              state <= S_IDLE;
        default:                                state <= S_IDLE;
      endcase
    end
  end

  assign bus.freeze_if_id = freeze;
  assign bus.bubble_ex    = bubble;
  assign bus.flush_id     = bus.br_taken & ~stall & ~pipe_hold;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.dmem_req     = dmem_req;
  assign bus.fwd_a_sel    = fwd_sel(ex_q.rs, ex_q.valid, mem_q, wb_q);
  assign bus.fwd_b_sel    = fwd_sel(ex_q.rt, ex_q.valid, mem_q, wb_q);
  assign bus.stall_cnt    = stall_cnt_q;

  // The WB slot only ever answers "who writes which register".
  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_q.mem_read, wb_q.mem_write, wb_q.rs, wb_q.rt};

endmodule
